// File: rtl/sdram_scheduler_if.sv
// Pin bundle between the SDRAM scheduler, its two request ports, the init
// sequencer handshake and the SDRAM command/data pins.
interface sdram_scheduler_if;
    logic        oinit_req;
    logic        oinit_enb;
    logic        iinit_fin;
    logic        oready;
    logic        ireq0;
    logic [21:0] iaddr0;
    logic        oack0;
    logic [15:0] ordata0;
    logic        ordvalid0;
    logic        ireq1;
    logic        iwe1;
    logic [21:0] iaddr1;
    logic [15:0] iwdata1;
    logic        oack1;
    logic [15:0] ordata1;
    logic        ordvalid1;
    logic [3:0]  ocmd;
    logic [12:0] oaddr;
    logic [1:0]  oba;
    logic [1:0]  odqm;
    logic [15:0] odq;
    logic        odq_oe;
    logic [15:0] idq;

    modport slave (
        input  iinit_fin, ireq0, iaddr0, ireq1, iwe1, iaddr1, iwdata1, idq,
        output oinit_req, oinit_enb, oready, oack0, ordata0, ordvalid0,
               oack1, ordata1, ordvalid1, ocmd, oaddr, oba, odqm, odq, odq_oe
    );

    modport master (
        output iinit_fin, ireq0, iaddr0, ireq1, iwe1, iaddr1, iwdata1, idq,
        input  oinit_req, oinit_enb, oready, oack0, ordata0, ordvalid0,
               oack1, ordata1, ordvalid1, ocmd, oaddr, oba, odqm, odq, odq_oe
    );
endinterface

// File: rtl/sdram_scheduler.sv
// Single-port SDRAM access scheduler: init hand-off, two-port single-word
// arbitration with auto-precharge accesses, and periodic AUTO REFRESH.
module sdram_scheduler #(
    parameter int T_RCD        = 2,
    parameter int T_REC        = 6,
    parameter int T_RFC        = 8,
    parameter int REF_INTERVAL = 780,
    parameter int RD_DLY       = 3
) (
    input  logic             iclk,
    input  logic             ireset_n,
    sdram_scheduler_if.slave bus
);
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_RCD  = 3'd2;
    localparam logic [2:0] ST_RW   = 3'd3;
    localparam logic [2:0] ST_REC  = 3'd4;
    localparam logic [2:0] ST_RFC  = 3'd5;

    localparam int CNT_MAX = (T_RFC > T_REC) ? ((T_RFC > T_RCD) ? T_RFC : T_RCD)
                                             : ((T_REC > T_RCD) ? T_REC : T_RCD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = $clog2(REF_INTERVAL);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  ref_tmr_q, ref_tmr_d;
    logic              ref_pend_q, ref_pend_d;
    logic [1:0]        bank_q, bank_d;
    logic [7:0]        col_q, col_d;
    logic              we_q, we_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              port_q, port_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [12:0]       addr_q, addr_d;
    logic [1:0]        ba_q, ba_d;
    logic [1:0]        dqm_q, dqm_d;
    logic [15:0]       dq_q, dq_d;
    logic              dq_oe_q, dq_oe_d;
    logic              init_req_q, init_req_d;
    logic              init_enb_q, init_enb_d;
    logic              ready_q, ready_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [15:0]       rdata0_q, rdata0_d;
    logic [15:0]       rdata1_q, rdata1_d;
    logic              rdvalid0_q, rdvalid0_d;
    logic              rdvalid1_q, rdvalid1_d;
    logic [RD_DLY-1:0] rd_vld_q, rd_vld_d;
    logic [RD_DLY-1:0] rd_port_q, rd_port_d;

    logic              accept_s;
    logic              sel_port_s;
    logic [21:0]       sel_addr_s;
    logic              ref_clr_s;
    logic              ref_wrap_s;
    logic              rd_start_s;

    // Request selection: refresh pending blocks both ports, port 0 beats port 1
    always_comb begin
        accept_s   = 1'b0;
        sel_port_s = 1'b0;
        sel_addr_s = bus.iaddr0;
        if ((state_q == ST_IDLE) && ready_q && !ref_pend_q) begin
            if (bus.ireq0) begin
                accept_s   = 1'b1;
                sel_port_s = 1'b0;
                sel_addr_s = bus.iaddr0;
            end else if (bus.ireq1) begin
                accept_s   = 1'b1;
                sel_port_s = 1'b1;
                sel_addr_s = bus.iaddr1;
            end else begin
                accept_s   = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Command sequencer: next registered pin values and state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bank_d     = bank_q;
        col_d      = col_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        port_d     = port_q;
        cmd_d      = CMD_NOP;
        addr_d     = addr_q;
        ba_d       = ba_q;
        dqm_d      = dqm_q;
        dq_d       = 16'h0000;
        dq_oe_d    = 1'b0;
        init_req_d = init_req_q;
        init_enb_d = init_enb_q;
        ready_d    = ready_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        ref_clr_s  = 1'b0;
        rd_start_s = 1'b0;

        case (state_q)
            ST_INIT: begin
                // Request stays high after init; the sequencer latches its own done
                init_req_d = 1'b1;
                init_enb_d = 1'b1;
                if (bus.iinit_fin) begin
                    state_d    = ST_IDLE;
                    init_enb_d = 1'b0;
                    ready_d    = 1'b1;
                    dqm_d      = 2'b00;
                end else begin
                    state_d    = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (ref_pend_q) begin
                    cmd_d     = CMD_REF;
                    ref_clr_s = 1'b1;
                    cnt_d     = CNT_W'(T_RFC);
                    state_d   = ST_RFC;
                end else if (accept_s) begin
                    cmd_d   = CMD_ACT;
                    ba_d    = sel_addr_s[21:20];
                    addr_d  = {1'b0, sel_addr_s[19:8]};
                    bank_d  = sel_addr_s[21:20];
                    col_d   = sel_addr_s[7:0];
                    port_d  = sel_port_s;
                    we_d    = sel_port_s & bus.iwe1;
                    wdata_d = bus.iwdata1;
                    ack0_d  = ~sel_port_s;
                    ack1_d  = sel_port_s;
                    cnt_d   = CNT_W'(T_RCD - 1);
                    state_d = (T_RCD > 1) ? ST_RCD : ST_RW;
                end else begin
                    cmd_d   = CMD_NOP;
                end
            end
            ST_RCD: begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_RW;
                end else begin
                    state_d = ST_RCD;
                end
            end
            ST_RW: begin
                // A10 high selects auto-precharge, so no explicit PRECHARGE is ever issued
                addr_d  = {2'b00, 1'b1, 2'b00, col_q};
                ba_d    = bank_q;
                cnt_d   = CNT_W'(T_REC);
                state_d = ST_REC;
                if (we_q) begin
                    cmd_d   = CMD_WR;
                    dq_d    = wdata_q;
                    dq_oe_d = 1'b1;
                end else begin
                    cmd_d      = CMD_RD;
                    rd_start_s = 1'b1;
                end
            end
            ST_REC, ST_RFC: begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Refresh timer: free-runs while the bus is owned, one saturating request flag
    always_comb begin
        ref_wrap_s = 1'b0;
        ref_tmr_d  = ref_tmr_q;
        if (ready_q) begin
            if (ref_tmr_q == TMR_W'(REF_INTERVAL - 1)) begin
                ref_tmr_d  = {TMR_W{1'b0}};
                ref_wrap_s = 1'b1;
            end else begin
                ref_tmr_d  = ref_tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ref_tmr_d = {TMR_W{1'b0}};
        end
        ref_pend_d = (ref_pend_q & ~ref_clr_s) | ref_wrap_s;
    end

    // Read return pipe: tag each READ with its port and capture idq RD_DLY edges later
    always_comb begin
        rd_vld_d     = rd_vld_q;
        rd_port_d    = rd_port_q;
        rd_vld_d[0]  = rd_start_s;
        rd_port_d[0] = port_q;
        for (int i = 1; i < RD_DLY; i++) begin
            rd_vld_d[i]  = rd_vld_q[i-1];
            rd_port_d[i] = rd_port_q[i-1];
        end
        rdvalid0_d = rd_vld_q[RD_DLY-1] & ~rd_port_q[RD_DLY-1];
        rdvalid1_d = rd_vld_q[RD_DLY-1] &  rd_port_q[RD_DLY-1];
        if (rdvalid0_d) begin
            rdata0_d = bus.idq;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (rdvalid1_d) begin
            rdata1_d = bus.idq;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // State and output registers
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= {CNT_W{1'b0}};
            ref_tmr_q  <= {TMR_W{1'b0}};
            ref_pend_q <= 1'b0;
            bank_q     <= 2'b00;
            col_q      <= 8'h00;
            we_q       <= 1'b0;
            wdata_q    <= 16'h0000;
            port_q     <= 1'b0;
            cmd_q      <= CMD_NOP;
            addr_q     <= 13'h0000;
            ba_q       <= 2'b00;
            dqm_q      <= 2'b11;
            dq_q       <= 16'h0000;
            dq_oe_q    <= 1'b0;
            init_req_q <= 1'b0;
            init_enb_q <= 1'b1;
            ready_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= 16'h0000;
            rdata1_q   <= 16'h0000;
            rdvalid0_q <= 1'b0;
            rdvalid1_q <= 1'b0;
            rd_vld_q   <= {RD_DLY{1'b0}};
            rd_port_q  <= {RD_DLY{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ref_tmr_q  <= ref_tmr_d;
            ref_pend_q <= ref_pend_d;
            bank_q     <= bank_d;
            col_q      <= col_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            ba_q       <= ba_d;
            dqm_q      <= dqm_d;
            dq_q       <= dq_d;
            dq_oe_q    <= dq_oe_d;
            init_req_q <= init_req_d;
            init_enb_q <= init_enb_d;
            ready_q    <= ready_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rdvalid0_q <= rdvalid0_d;
            rdvalid1_q <= rdvalid1_d;
            rd_vld_q   <= rd_vld_d;
            rd_port_q  <= rd_port_d;
        end
    end

    assign bus.ocmd      = cmd_q;
    assign bus.oaddr     = addr_q;
    assign bus.oba       = ba_q;
    assign bus.odqm      = dqm_q;
    assign bus.odq       = dq_q;
    assign bus.odq_oe    = dq_oe_q;
    assign bus.oinit_req = init_req_q;
    assign bus.oinit_enb = init_enb_q;
    assign bus.oready    = ready_q;
    assign bus.oack0     = ack0_q;
    assign bus.oack1     = ack1_q;
    assign bus.ordata0   = rdata0_q;
    assign bus.ordata1   = rdata1_q;
    assign bus.ordvalid0 = rdvalid0_q;
    assign bus.ordvalid1 = rdvalid1_q;

endmodule

// File: tb/tb_sdram_scheduler.sv
// Bench for sdram_scheduler: a behavioural SDRAM array behind the pins and a
// requester-side memory image; reads must return what the requester wrote.
module tb_sdram_scheduler;
    localparam int T_RCD = 2, T_REC = 6, T_RFC = 8, REF_INTERVAL = 780, RD_DLY = 3;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100, REF = 4'b0001;

    typedef struct { int cyc; logic [3:0] cmd; } ev_t;

    logic iclk = 1'b0;
    logic ireset_n;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    sdram_scheduler_if bus();

    sdram_scheduler #(.T_RCD(T_RCD), .T_REC(T_REC), .T_RFC(T_RFC),
                      .REF_INTERVAL(REF_INTERVAL), .RD_DLY(RD_DLY))
        dut (.iclk(iclk), .ireset_n(ireset_n), .bus(bus));

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    logic [15:0] sd_mem  [logic [21:0]];
    logic [15:0] ref_mem [logic [21:0]];
    logic [11:0] open_row [4];
    int          rd_cd = 0;
    logic [15:0] rd_word;
    ev_t         ev_log [$];
    logic [21:0] pool [8];

    function automatic logic [15:0] init_word(input logic [21:0] a);
        return a[15:0] ^ {a[21:16], 10'h2A5};
    endfunction

    function automatic logic [15:0] expect_word(input logic [21:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // SDRAM array model: data appears on idq only in the cycle before the capture edge
    always @(negedge iclk) begin
        logic [21:0] a;
        if (rd_cd == 1) bus.idq = rd_word;
        else            bus.idq = 16'($urandom);
        if (rd_cd > 0) rd_cd = rd_cd - 1;
        case (bus.ocmd)
            ACT: open_row[bus.oba] = bus.oaddr[11:0];
            WR: begin
                a = {bus.oba, open_row[bus.oba], bus.oaddr[7:0]};
                if (bus.odq_oe) sd_mem[a] = bus.odq;
            end
            RD: begin
                a = {bus.oba, open_row[bus.oba], bus.oaddr[7:0]};
                rd_word = sd_mem.exists(a) ? sd_mem[a] : init_word(a);
                rd_cd = RD_DLY - 1;
            end
            default: ;
        endcase
        if (bus.ocmd != NOP) ev_log.push_back('{cyc, bus.ocmd});
    end

    // One single-word access, checked cycle by cycle from request to end of recovery
    task automatic access(input int port, input logic we, input logic [21:0] a, input logic [15:0] wd);
        int n;
        logic acked, own_v, oth_v, exp_v;
        logic [15:0] own_d, exp;
        logic [3:0] want;
        exp = expect_word(a);
        if (port == 0) begin bus.ireq0 = 1'b1; bus.iaddr0 = a; end
        else begin bus.ireq1 = 1'b1; bus.iwe1 = we; bus.iaddr1 = a; bus.iwdata1 = wd; end
        n = 0;
        do begin
            @(negedge iclk);
            n++;
            acked = (port == 0) ? bus.oack0 : bus.oack1;
        end while (!acked && n < 40);
        vectors++;
        if (!acked) begin
            errors++;
            $display("FAIL ack_timeout port%0d: got no ack, required ack within 40 cycles", port);
            bus.ireq0 = 1'b0; bus.ireq1 = 1'b0;
            return;
        end
        vectors++;
        if (bus.ocmd !== ACT || bus.oba !== a[21:20] || bus.oaddr !== {1'b0, a[19:8]}) begin
            errors++;
            $display("FAIL active port%0d: got cmd=%b ba=%0d addr=%h, required cmd=%b ba=%0d addr=%h",
                     port, bus.ocmd, bus.oba, bus.oaddr, ACT, a[21:20], {1'b0, a[19:8]});
        end
        vectors++;
        if (((port == 0) ? bus.oack1 : bus.oack0) !== 1'b0) begin
            errors++;
            $display("FAIL other_ack port%0d: got 1, required 0", port);
        end
        bus.ireq0 = 1'b0; bus.ireq1 = 1'b0;
        if (we) ref_mem[a] = wd;
        for (int k = 1; k <= T_RCD + T_REC; k++) begin
            @(negedge iclk);
            want = (k == T_RCD) ? (we ? WR : RD) : NOP;
            vectors++;
            if (bus.ocmd !== want) begin
                errors++;
                $display("FAIL cmd+%0d: got %b, required %b", k, bus.ocmd, want);
            end
            if (k == T_RCD) begin
                vectors++;
                if (bus.oaddr !== {2'b00, 1'b1, 2'b00, a[7:0]} || bus.oba !== a[21:20]) begin
                    errors++;
                    $display("FAIL rw_addr: got addr=%h ba=%0d, required addr=%h ba=%0d",
                             bus.oaddr, bus.oba, {2'b00, 1'b1, 2'b00, a[7:0]}, a[21:20]);
                end
                vectors++;
                if (bus.odq_oe !== we) begin
                    errors++;
                    $display("FAIL rw_oe: got %b, required %b", bus.odq_oe, we);
                end
                if (we) begin
                    vectors++;
                    if (bus.odq !== wd) begin
                        errors++;
                        $display("FAIL wdata: got %h, required %h", bus.odq, wd);
                    end
                end
            end
            if (k == T_RCD + 1) begin
                vectors++;
                if (bus.odq_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL oe_release: got %b, required 0", bus.odq_oe);
                end
            end
            own_v = (port == 0) ? bus.ordvalid0 : bus.ordvalid1;
            oth_v = (port == 0) ? bus.ordvalid1 : bus.ordvalid0;
            own_d = (port == 0) ? bus.ordata0 : bus.ordata1;
            exp_v = !we && (k == T_RCD + RD_DLY);
            vectors++;
            if (own_v !== exp_v || oth_v !== 1'b0) begin
                errors++;
                $display("FAIL rdvalid+%0d port%0d: got own=%b other=%b, required own=%b other=0",
                         k, port, own_v, oth_v, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if (own_d !== exp) begin
                    errors++;
                    $display("FAIL rdata port%0d addr=%h: got %h, required %h", port, a, own_d, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        ireset_n = 1'b0;
        bus.iinit_fin = 1'b0; bus.ireq0 = 1'b0; bus.ireq1 = 1'b0; bus.iwe1 = 1'b0;
        bus.iaddr0 = 22'h0; bus.iaddr1 = 22'h0; bus.iwdata1 = 16'h0; bus.idq = 16'h0;
        repeat (3) @(negedge iclk);
        vectors++;
        if ({bus.ocmd, bus.oaddr, bus.oba, bus.odqm} !== {NOP, 13'h0, 2'b00, 2'b11}) begin
            errors++;
            $display("FAIL reset_pins: got %b %h %b %b, required 0111 0000 00 11",
                     bus.ocmd, bus.oaddr, bus.oba, bus.odqm);
        end
        vectors++;
        if ({bus.odq, bus.odq_oe, bus.oinit_req, bus.oinit_enb, bus.oready} !== {16'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctl: got dq=%h oe=%b req=%b enb=%b rdy=%b, required 0000 0 0 1 0",
                     bus.odq, bus.odq_oe, bus.oinit_req, bus.oinit_enb, bus.oready);
        end
        vectors++;
        if ({bus.oack0, bus.oack1, bus.ordvalid0, bus.ordvalid1, bus.ordata0, bus.ordata1} !== {4'b0000, 32'h0}) begin
            errors++;
            $display("FAIL reset_ports: got %b%b%b%b %h %h, required 0000 0000 0000",
                     bus.oack0, bus.oack1, bus.ordvalid0, bus.ordvalid1, bus.ordata0, bus.ordata1);
        end
        ireset_n = 1'b1;
        bus.ireq1 = 1'b1; bus.iaddr1 = 22'h155555;
        for (int k = 1; k <= 20; k++) begin
            @(negedge iclk);
            vectors++;
            if (bus.oinit_req !== 1'b1 || bus.oinit_enb !== 1'b1 || bus.oready !== 1'b0 ||
                bus.ocmd !== NOP || bus.oack1 !== 1'b0) begin
                errors++;
                $display("FAIL init_wait%0d: got req=%b enb=%b rdy=%b cmd=%b ack1=%b, required 1 1 0 0111 0",
                         k, bus.oinit_req, bus.oinit_enb, bus.oready, bus.ocmd, bus.oack1);
            end
        end
        bus.iinit_fin = 1'b1;
        @(negedge iclk);
        vectors++;
        if (bus.oinit_enb !== 1'b0 || bus.oready !== 1'b1 || bus.odqm !== 2'b00 ||
            bus.oack1 !== 1'b0 || bus.oinit_req !== 1'b1) begin
            errors++;
            $display("FAIL init_done: got enb=%b rdy=%b dqm=%b ack1=%b req=%b, required 0 1 00 0 1",
                     bus.oinit_enb, bus.oready, bus.odqm, bus.oack1, bus.oinit_req);
        end
        bus.ireq1 = 1'b0;
        @(negedge iclk);
    endtask

    task automatic test_write();
        access(1, 1'b1, 22'h2ABCDE, 16'h1234);
    endtask

    task automatic test_read();
        sd_mem[22'h000010]  = 16'hBEEF;
        ref_mem[22'h000010] = 16'hBEEF;
        access(0, 1'b0, 22'h000010, 16'h0000);
        access(1, 1'b0, 22'h2ABCDE, 16'h0000);
    endtask

    task automatic test_arbitration();
        int n, c0, c1;
        bus.ireq0 = 1'b1; bus.iaddr0 = 22'h1F0033;
        bus.ireq1 = 1'b1; bus.iwe1 = 1'b1; bus.iaddr1 = 22'h0C1234; bus.iwdata1 = 16'h5A5A;
        n = 0;
        do begin @(negedge iclk); n++; end while (!bus.oack0 && n < 40);
        vectors++;
        if (bus.oack0 !== 1'b1 || bus.oack1 !== 1'b0) begin
            errors++;
            $display("FAIL arb_first: got ack0=%b ack1=%b, required ack0=1 ack1=0", bus.oack0, bus.oack1);
        end
        c0 = cyc;
        bus.ireq0 = 1'b0;
        n = 0;
        do begin @(negedge iclk); n++; end while (!bus.oack1 && n < 40);
        c1 = cyc;
        bus.ireq1 = 1'b0;
        if (bus.oack1) ref_mem[22'h0C1234] = 16'h5A5A;
        vectors++;
        if (bus.oack1 !== 1'b1 || (c1 - c0) != T_RCD + 1 + T_REC) begin
            errors++;
            $display("FAIL arb_spacing: got ack1=%b after %0d cycles, required ack1=1 after %0d",
                     bus.oack1, c1 - c0, T_RCD + 1 + T_REC);
        end
        repeat (T_RCD + T_REC) @(negedge iclk);
        access(0, 1'b0, 22'h0C1234, 16'h0000);
    endtask

    task automatic test_refresh();
        logic [21:0] a;
        logic        we;
        logic [15:0] wd;
        logic [15:0] q1 [$];
        int nref, last_ref;
        ev_log.delete();
        a = pool[$urandom_range(7)]; we = 1'($urandom); wd = 16'($urandom);
        bus.ireq1 = 1'b1; bus.iaddr1 = a; bus.iwe1 = we; bus.iwdata1 = wd;
        for (int k = 0; k < 2000 + T_RCD + T_REC + 4; k++) begin
            @(negedge iclk);
            if (bus.ordvalid1) begin
                vectors++;
                if (q1.size() == 0 || bus.ordata1 !== q1[0]) begin
                    errors++;
                    $display("FAIL ref_rdata: got %h, required %h (pending %0d)",
                             bus.ordata1, (q1.size() > 0) ? q1[0] : 16'h0, q1.size());
                end
                if (q1.size() > 0) void'(q1.pop_front());
            end
            if (bus.oack1) begin
                if (we) ref_mem[a] = wd;
                else    q1.push_back(expect_word(a));
                a = pool[$urandom_range(7)]; we = 1'($urandom); wd = 16'($urandom);
                bus.iaddr1 = a; bus.iwe1 = we; bus.iwdata1 = wd;
            end
            if (k == 1999) bus.ireq1 = 1'b0;
        end
        vectors++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL ref_returns: got %0d reads outstanding, required 0", q1.size());
        end
        nref = 0; last_ref = -1;
        foreach (ev_log[i]) begin
            if (ev_log[i].cmd == REF) begin
                nref++;
                if (i > 0) begin
                    vectors++;
                    if (!((ev_log[i-1].cmd == RD || ev_log[i-1].cmd == WR) &&
                          ev_log[i].cyc - ev_log[i-1].cyc >= T_REC + 1)) begin
                        errors++;
                        $display("FAIL ref_from_idle@%0d: got prev cmd %b %0d cycles before, required RD/WR >= %0d",
                                 ev_log[i].cyc, ev_log[i-1].cmd, ev_log[i].cyc - ev_log[i-1].cyc, T_REC + 1);
                    end
                end
                if (i + 1 < ev_log.size()) begin
                    vectors++;
                    if (ev_log[i+1].cyc - ev_log[i].cyc < T_RFC + 1) begin
                        errors++;
                        $display("FAIL ref_trfc@%0d: got next cmd %b after %0d cycles, required >= %0d",
                                 ev_log[i].cyc, ev_log[i+1].cmd, ev_log[i+1].cyc - ev_log[i].cyc, T_RFC + 1);
                    end
                end
                if (last_ref >= 0) begin
                    vectors++;
                    if (ev_log[i].cyc - last_ref < REF_INTERVAL - (T_RCD + 1 + T_REC) ||
                        ev_log[i].cyc - last_ref > REF_INTERVAL + (T_RCD + 1 + T_REC)) begin
                        errors++;
                        $display("FAIL ref_interval: got %0d cycles, required %0d +/- %0d",
                                 ev_log[i].cyc - last_ref, REF_INTERVAL, T_RCD + 1 + T_REC);
                    end
                end
                last_ref = ev_log[i].cyc;
            end
        end
        vectors++;
        if (nref < 2 || nref > 3) begin
            errors++;
            $display("FAIL ref_count: got %0d refreshes in 2000 cycles, required 2..3", nref);
        end
    endtask

    task automatic test_random();
        int port;
        for (int i = 0; i < 40; i++) begin
            port = $urandom_range(1);
            access(port, (port == 1) ? 1'($urandom) : 1'b0, pool[$urandom_range(7)], 16'($urandom));
            repeat ($urandom_range(2)) @(negedge iclk);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.ireq1 = 1'b1; bus.iwe1 = 1'b0; bus.iaddr1 = pool[3];
        n = 0;
        do begin @(negedge iclk); n++; end while (!bus.oack1 && n < 40);
        bus.ireq1 = 1'b0;
        vectors++;
        if (bus.ocmd !== ACT) begin
            errors++;
            $display("FAIL mid_active: got %b, required %b", bus.ocmd, ACT);
        end
        @(negedge iclk);
        ireset_n = 1'b0;
        bus.iinit_fin = 1'b0;
        #1;
        vectors++;
        if (bus.ocmd !== NOP || bus.odqm !== 2'b11 || bus.oinit_enb !== 1'b1 ||
            bus.oready !== 1'b0 || bus.oinit_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got cmd=%b dqm=%b enb=%b rdy=%b req=%b, required 0111 11 1 0 0",
                     bus.ocmd, bus.odqm, bus.oinit_enb, bus.oready, bus.oinit_req);
        end
        repeat (3) @(negedge iclk);
        ireset_n = 1'b1;
        bus.ireq0 = 1'b1; bus.iaddr0 = pool[5];
        for (int k = 1; k <= 10; k++) begin
            @(negedge iclk);
            vectors++;
            if (bus.oinit_req !== 1'b1 || bus.oinit_enb !== 1'b1 || bus.oready !== 1'b0 ||
                bus.oack0 !== 1'b0 || bus.ocmd !== NOP || bus.ordvalid1 !== 1'b0) begin
                errors++;
                $display("FAIL reinit%0d: got req=%b enb=%b rdy=%b ack0=%b cmd=%b v1=%b, required 1 1 0 0 0111 0",
                         k, bus.oinit_req, bus.oinit_enb, bus.oready, bus.oack0, bus.ocmd, bus.ordvalid1);
            end
        end
        bus.iinit_fin = 1'b1;
        @(negedge iclk);
        vectors++;
        if (bus.oready !== 1'b1 || bus.oinit_enb !== 1'b0) begin
            errors++;
            $display("FAIL reinit_done: got rdy=%b enb=%b, required 1 0", bus.oready, bus.oinit_enb);
        end
        bus.ireq0 = 1'b0;
        access(0, 1'b0, pool[5], 16'h0000);
        access(1, 1'b1, pool[6], 16'hC0DE);
        access(0, 1'b0, pool[6], 16'h0000);
    endtask

    initial begin
        pool[0] = 22'h2ABCDE;
        pool[1] = 22'h000010;
        for (int i = 2; i < 8; i++) pool[i] = 22'($urandom);
        pool[7] = {pool[2][21:20], ~pool[2][19:8], pool[2][7:0]};
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_refresh();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 50000 cycles, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdram_scheduler.md
Name: sdram_scheduler

Overview:
Single-port SDRAM access scheduler that sits after the SDRAM init sequencer on the CYC1000 (8 MB, x16, 4 banks, 4096 rows, 256 columns).
- Starts the init sequencer, hands bus ownership to it, then takes the bus once init reports finish.
- Arbitrates single-word accesses between a read-only display port (port 0) and a read/write port (port 1).
- Inserts periodic AUTO REFRESH.
- Uses the init mode: CAS 2, burst 1, single-location write. All accesses use auto-precharge.

Parameters:
- T_RCD, 2, iclk cycles from ACTIVE to READ/WRITE (NOPs between = T_RCD-1).
- T_REC, 6, NOP cycles after READ/WRITE before the next command (covers tRAS, tWR, tRP).
- T_RFC, 8, NOP cycles after AUTO REFRESH.
- REF_INTERVAL, 780, iclk cycles between refresh requests (7.8 us at 100 MHz).
- RD_DLY, 3, iclk rising edges after the READ-issuing edge at which idq is sampled.

Ports:
- iclk  in  1  system clock; the SDRAM clock is ~iclk, generated outside this block.
- ireset_n  in  1  asynchronous active-low reset.
- oinit_req  out  1  start request to the init sequencer.
- oinit_enb  out  1  1 = init sequencer owns the SDRAM pins; the top-level muxes on this.
- iinit_fin  in  1  init sequencer finished.
- oready  out  1  1 = scheduler owns the bus and accepts requests.
- ireq0  in  1  port 0 read request, level; held until ack.
- iaddr0  in  22  {bank[1:0], row[11:0], col[7:0]}.
- oack0  out  1  one-cycle pulse; request accepted, iaddr0 sampled.
- ordata0  out  16  read data.
- ordvalid0  out  1  one-cycle pulse; ordata0 valid.
- ireq1  in  1  port 1 request, level; held until ack.
- iwe1  in  1  1 = write, 0 = read; sampled with the request.
- iaddr1  in  22  same format as iaddr0.
- iwdata1  in  16  write data.
- oack1  out  1  one-cycle accept pulse.
- ordata1  out  16  read data.
- ordvalid1  out  1  one-cycle read-data pulse.
- ocmd  out  4  {CS_N, RAS_N, CAS_N, WE_N}.
- oaddr  out  13  SDRAM address bus.
- oba  out  2  SDRAM bank address.
- odqm  out  2  {UDQM, LDQM}.
- odq  out  16  write data.
- odq_oe  out  1  DQ output enable.
- idq  in  16  SDRAM read data.

Behaviour:
Reset values (all outputs registered):
- ocmd=4'b0111 (NOP), oaddr=0, oba=0, odqm=2'b11.
- odq=0, odq_oe=0.
- oinit_req=0, oinit_enb=1, oready=0.
- All ack/valid outputs=0, ordata=0.

States:
- INIT: oinit_req=1, oinit_enb=1. On iinit_fin=1 go to IDLE and set oinit_enb=0, oready=1, odqm=2'b00. oinit_req stays 1 afterwards; the init sequencer latches done.
- IDLE: ocmd=NOP. Priority is refresh pending > ireq0 > ireq1.
  - Accepting a request issues ACTIVE (0011) with oba=addr[21:20], oaddr={1'b0, addr[19:8]}.
  - The same cycle pulses the port's ack and latches addr, iwe1 and iwdata1.
- RCD: NOP for T_RCD-1 cycles.
- RW:
  - READ is 0101; WRITE is 0100.
  - oaddr={2'b00, 1'b1 (A10 auto-precharge), 2'b00, col[7:0]}, oba=bank.
  - On WRITE, odq=wdata and odq_oe=1 for this cycle only.
- REC: NOP for T_REC cycles, then IDLE.
- REF: AUTO REFRESH (0001), clears the refresh-pending flag, then NOP for T_RFC cycles, then IDLE.

Read return:
- A delay pipe samples idq on the RD_DLY-th edge after the READ edge.
- It pulses ordvalid of the owning port in the same cycle ordata updates.
- T_REC is at least RD_DLY, so returns never overlap.

Refresh timer:
- Counts only while oready=1 and wraps at REF_INTERVAL-1.
- Wrapping sets refresh-pending; the flag saturates and never queues a second refresh.
- Refresh waits for an in-flight access to finish; it never preempts one.

Boundary rules:
- Requests arriving while not IDLE or oready=0 are not acked and must be held by the requester.
- Simultaneous ireq0 and ireq1: port 0 wins; port 1 is served on the next IDLE slot with no refresh pending and ireq0=0.
- Back-to-back requests from one port are allowed; minimum spacing is T_RCD+1+T_REC cycles.
- ireset_n asserted at any time returns every output to its reset value immediately and re-enters INIT. The pending flag and timer clear.

Test Plan:
1. Reset release, iinit_fin high after 20 cycles: oinit_req=1 from the first cycle, oinit_enb falls and oready rises the cycle after iinit_fin. No ACTIVE issued before that.
2. Port 1 write, addr=22'h2ABCDE, wdata=16'h1234:
   - ACTIVE with oba=2, oaddr=13'h0ABC.
   - WRITE 2 cycles later with oaddr=13'h04DE, odq=16'h1234, odq_oe=1 for one cycle.
3. Port 0 read, addr=22'h000010, model returns 16'hBEEF: ordvalid0 pulses exactly RD_DLY cycles after the READ cycle with ordata0=16'hBEEF. ordvalid1 stays 0.
4. ireq0 and ireq1 asserted in the same cycle: oack0 pulses first, then oack1 exactly T_RCD+1+T_REC cycles later.
5. Hold ireq1 continuously for 2000 cycles: an AUTO REFRESH appears every ~REF_INTERVAL cycles, each only from IDLE. It is followed by T_RFC NOPs with no ACTIVE during them.
6. Assert ireset_n=0 in the cycle after an ACTIVE: ocmd=NOP and odqm=2'b11 immediately, oinit_enb=1. The INIT sequence reruns after release.
